// File: rtl/pe_demux_pkg.sv
// Shared definitions for the PE input demultiplexer: header field positions,
// FSM state encoding and header field extraction helpers.
package pe_demux_pkg;

    localparam int LEN_LSB = 32;
    localparam int LEN_MSB = 47;
    localparam int SEL_BIT = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ROUTE = 1'b1
    } state_t;

    function automatic logic [15:0] hdr_len(input logic [63:0] w);
        return w[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic hdr_sel(input logic [63:0] w);
        return w[SEL_BIT];
    endfunction

endpackage

// File: rtl/pe_demux_fifo.sv
// Synchronous first-word-fall-through FIFO; a write while full is dropped.
module pe_demux_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign empty   = (count_r == {(AW+1){1'b0}});
    assign full    = (count_r == FULL_CNT);
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign wr_ok_s = wr_en & ~full;
    assign rd_ok_s = rd_en & ~empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous read and write keep count steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pe_in_demux.sv
// Routes length-prefixed packets from one input stream to one of two PE ports.
// Optional header forwarding onto the output port: define PE_DEMUX_HDR_FWD_EN.
module pe_in_demux
    import pe_demux_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic        CLK,
    input  logic        SYS_RST_N,
    input  logic [63:0] D,
    input  logic        D_VALID,
    output logic        D_BP,
    output logic [63:0] Q0,
    output logic [63:0] Q1,
    output logic        Q0_VALID,
    output logic        Q1_VALID,
    input  logic        Q0_BP,
    input  logic        Q1_BP
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] BP_THRESH = CW'(DEPTH - AFULL_MARGIN);

    state_t         state_r;
    state_t         state_s;
    logic           sel_r;
    logic [15:0]    cnt_r;
    logic           ovf_r;
    logic           d_bp_r;
    logic [63:0]    q0_r;
    logic [63:0]    q1_r;
    logic           q0_valid_r;
    logic           q1_valid_r;

    logic [63:0]    fifo_dout_s;
    logic           fifo_empty_s;
    logic           fifo_full_s;
    logic [CW-1:0]  fifo_count_s;
    logic           pop_s;
    logic           load_s;
    logic           dec_s;
    logic           emit_s;
    logic           emit_sel_s;
    logic           sel_bp_s;
    logic [15:0]    hdr_len_s;
    logic           hdr_sel_s;
`ifdef PE_DEMUX_HDR_FWD_EN
    logic           hdr_bp_s;
`endif

    pe_demux_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (SYS_RST_N),
        .wr_en   (D_VALID),
        .wr_data (D),
        .rd_en   (pop_s),
        .rd_data (fifo_dout_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s),
        .count   (fifo_count_s)
    );

    assign hdr_len_s = hdr_len(fifo_dout_s);
    assign hdr_sel_s = hdr_sel(fifo_dout_s);
    assign sel_bp_s  = sel_r ? Q1_BP : Q0_BP;
`ifdef PE_DEMUX_HDR_FWD_EN
    assign hdr_bp_s  = hdr_sel_s ? Q1_BP : Q0_BP;
`endif

    // Next-state and pop/emit decisions; BP is used combinationally so a
    // rising BP blocks the pop in the same cycle.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        load_s     = 1'b0;
        dec_s      = 1'b0;
        emit_s     = 1'b0;
        emit_sel_s = sel_r;
        case (state_r)
            ST_IDLE: begin
`ifdef PE_DEMUX_HDR_FWD_EN
                if (!fifo_empty_s && !hdr_bp_s) begin
                    pop_s      = 1'b1;
                    load_s     = 1'b1;
                    emit_s     = 1'b1;
                    emit_sel_s = hdr_sel_s;
                    state_s    = (hdr_len_s != 16'd0) ? ST_ROUTE : ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    load_s  = 1'b1;
                    state_s = (hdr_len_s != 16'd0) ? ST_ROUTE : ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
            ST_ROUTE: begin
                if (!fifo_empty_s && !sel_bp_s) begin
                    pop_s   = 1'b1;
                    dec_s   = 1'b1;
                    emit_s  = 1'b1;
                    state_s = (cnt_r == 16'd1) ? ST_IDLE : ST_ROUTE;
                end else begin
                    state_s = ST_ROUTE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, packet context, sticky overflow flag and upstream backpressure.
    always_ff @(posedge CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_r <= ST_IDLE;
            sel_r   <= 1'b0;
            cnt_r   <= 16'd0;
            ovf_r   <= 1'b0;
            d_bp_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                sel_r <= hdr_sel_s;
                cnt_r <= hdr_len_s;
            end else if (dec_s) begin
                cnt_r <= cnt_r - 16'd1;
            end
            ovf_r  <= ovf_r | (D_VALID & fifo_full_s);
            d_bp_r <= (fifo_count_s >= BP_THRESH);
        end
    end

    // Output registers; data holds its last value while VALID is low.
    always_ff @(posedge CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            q0_r       <= 64'd0;
            q1_r       <= 64'd0;
            q0_valid_r <= 1'b0;
            q1_valid_r <= 1'b0;
        end else begin
            q0_valid_r <= emit_s & ~emit_sel_s;
            q1_valid_r <= emit_s & emit_sel_s;
            if (emit_s && !emit_sel_s) begin
                q0_r <= fifo_dout_s;
            end
            if (emit_s && emit_sel_s) begin
                q1_r <= fifo_dout_s;
            end
        end
    end

    assign D_BP     = d_bp_r;
    assign Q0       = q0_r;
    assign Q1       = q1_r;
    assign Q0_VALID = q0_valid_r;
    assign Q1_VALID = q1_valid_r;

endmodule

// File: tb/tb_pe_in_demux.sv
// Directed scoreboard bench for pe_in_demux (default DEPTH=16, AFULL_MARGIN=4).
module tb_pe_in_demux;

    logic        CLK = 1'b0;
    logic        SYS_RST_N = 1'b1;
    logic [63:0] D = 64'd0;
    logic        D_VALID = 1'b0;
    logic        D_BP;
    logic [63:0] Q0, Q1;
    logic        Q0_VALID, Q1_VALID;
    logic        Q0_BP = 1'b0;
    logic        Q1_BP = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic [63:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    pe_in_demux dut (
        .CLK       (CLK),
        .SYS_RST_N (SYS_RST_N),
        .D         (D),
        .D_VALID   (D_VALID),
        .D_BP      (D_BP),
        .Q0        (Q0),
        .Q1        (Q1),
        .Q0_VALID  (Q0_VALID),
        .Q1_VALID  (Q1_VALID),
        .Q0_BP     (Q0_BP),
        .Q1_BP     (Q1_BP)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] hdr(input logic [15:0] len, input logic sel);
        return {16'hA5A5, len, 31'h0ABCDE00, sel};
    endfunction

    function automatic exp_t mk(input logic port, input logic [63:0] data, input int at);
        exp_t x;
        x.port = port;
        x.data = data;
        x.at   = at;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_q0"}, Q0, 64'd0);
        chk({tag, "_q1"}, Q1, 64'd0);
        chk({tag, "_q0v"}, {63'd0, Q0_VALID}, 64'd0);
        chk({tag, "_q1v"}, {63'd0, Q1_VALID}, 64'd0);
        chk({tag, "_dbp"}, {63'd0, D_BP}, 64'd0);
    endtask

    // Output monitor: every VALID must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (Q0_VALID || Q1_VALID) begin
            checks++;
            assert (!(Q0_VALID && Q1_VALID)) else begin
                errors++;
                $error("FAIL both_valid observed=%0b%0b expected=one_hot", Q0_VALID, Q1_VALID);
            end
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed q0v=%0b q1v=%0b q0=%0h q1=%0h expected=none",
                       Q0_VALID, Q1_VALID, Q0, Q1);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (Q1_VALID === e.port) else begin
                    errors++;
                    $error("FAIL out_port observed=%0b expected=%0b", Q1_VALID, e.port);
                end
                checks++;
                assert ((Q1_VALID ? Q1 : Q0) === e.data) else begin
                    errors++;
                    $error("FAIL out_data observed=%0h expected=%0h", (Q1_VALID ? Q1 : Q0), e.data);
                end
                if (e.at >= 0) begin
                    checks++;
                    assert (cyc == e.at) else begin
                        errors++;
                        $error("FAIL out_cycle observed=%0d expected=%0d", cyc, e.at);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        int occ;
        logic dbp_exp;
        logic [63:0] h;

        // Reset at start
        #1 SYS_RST_N = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("rst0");
        @(negedge CLK);
        SYS_RST_N = 1'b1;
        @(negedge CLK);

        // Basic packet LEN=3 to port 0, latency 3
        c0 = cyc;
        h = hdr(16'd3, 1'b0);
`ifdef PE_DEMUX_HDR_FWD_EN
        sb.push_back(mk(1'b0, h, c0 + 2));
`endif
        sb.push_back(mk(1'b0, 64'hAAAA_0000_0000_000A, c0 + 3));
        sb.push_back(mk(1'b0, 64'hBBBB_0000_0000_000B, c0 + 4));
        sb.push_back(mk(1'b0, 64'hCCCC_0000_0000_000C, c0 + 5));
        D = h; D_VALID = 1'b1;
        @(negedge CLK); D = 64'hAAAA_0000_0000_000A;
        @(negedge CLK); D = 64'hBBBB_0000_0000_000B;
        @(negedge CLK); D = 64'hCCCC_0000_0000_000C;
        @(negedge CLK); D_VALID = 1'b0;
        wait_drain("t1_drain");
        chk("t1_q0_hold", Q0, 64'hCCCC_0000_0000_000C);
        chk("t1_q1_untouched", Q1, 64'd0);

        // Port 1 packet blocked by Q1_BP for 5 cycles, Q0_BP toggling
        c0 = cyc;
        h = hdr(16'd2, 1'b1);
`ifdef PE_DEMUX_HDR_FWD_EN
        sb.push_back(mk(1'b1, h, c0 + 2));
`endif
        sb.push_back(mk(1'b1, 64'h1111_2222_3333_4444, c0 + 8));
        sb.push_back(mk(1'b1, 64'h5555_6666_7777_8888, c0 + 9));
        D = h; D_VALID = 1'b1;
        @(negedge CLK); D = 64'h1111_2222_3333_4444;
        @(negedge CLK); D = 64'h5555_6666_7777_8888; Q1_BP = 1'b1; Q0_BP = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            D_VALID = 1'b0;
            Q0_BP = ~Q0_BP;
        end
        @(negedge CLK); Q1_BP = 1'b0; Q0_BP = 1'b0;
        wait_drain("t2_drain");
        chk("t2_q1_hold", Q1, 64'h5555_6666_7777_8888);

        // LEN=0 packet followed by LEN=1 packet on port 1
`ifdef PE_DEMUX_HDR_FWD_EN
        sb.push_back(mk(1'b0, hdr(16'd0, 1'b0), -1));
        sb.push_back(mk(1'b1, hdr(16'd1, 1'b1), -1));
`endif
        sb.push_back(mk(1'b1, 64'hDEAD_BEEF_0000_00FF, -1));
        D = hdr(16'd0, 1'b0); D_VALID = 1'b1;
        @(negedge CLK); D = hdr(16'd1, 1'b1);
        @(negedge CLK); D = 64'hDEAD_BEEF_0000_00FF;
        @(negedge CLK); D_VALID = 1'b0;
        wait_drain("t4_drain");
`ifdef PE_DEMUX_HDR_FWD_EN
        chk("t4_q0", Q0, hdr(16'd0, 1'b0));
`else
        chk("t4_q0_no_output", Q0, 64'hCCCC_0000_0000_000C);
`endif
        chk("t4_q1", Q1, 64'hDEAD_BEEF_0000_00FF);

        // Fill the FIFO with both ports blocked: D_BP timing and overflow
        h = hdr(16'd100, 1'b0);
`ifdef PE_DEMUX_HDR_FWD_EN
        sb.push_back(mk(1'b0, h, -1));
`endif
        D = h; D_VALID = 1'b1;
        @(negedge CLK); D_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        Q0_BP = 1'b1; Q1_BP = 1'b1;
        chk("t3_dbp_init", {63'd0, D_BP}, 64'd0);
        chk("t3_ovf_init", {63'd0, dut.ovf_r}, 64'd0);
        occ = 0;
        for (int i = 0; i < 17; i++) begin
            D = 64'h0F00_0000_0000_0000 | 64'(i); D_VALID = 1'b1;
            @(negedge CLK);
            dbp_exp = (occ >= 12);
            if (occ < 16) occ++;
            chk($sformatf("t3_dbp_w%0d", i + 1), {63'd0, D_BP}, {63'd0, dbp_exp});
            chk($sformatf("t3_ovf_w%0d", i + 1), {63'd0, dut.ovf_r}, {63'd0, (i == 16)});
        end
        D_VALID = 1'b0;
        @(negedge CLK);
        chk("t3_ovf_sticky", {63'd0, dut.ovf_r}, 64'd1);

        // Reset clears the full FIFO, overflow flag and outputs
        SYS_RST_N = 1'b0; Q0_BP = 1'b0; Q1_BP = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("rst1");
        chk("rst1_ovf", {63'd0, dut.ovf_r}, 64'd0);
        SYS_RST_N = 1'b1;
        @(negedge CLK);

        // Reset mid-packet (2 of 5 words), then a fresh packet
        sb.push_back(mk(1'b0, 64'h0000_0000_0000_0001, -1));
        sb.push_back(mk(1'b0, 64'h0000_0000_0000_0002, -1));
`ifdef PE_DEMUX_HDR_FWD_EN
        sb.push_front(mk(1'b0, hdr(16'd5, 1'b0), -1));
`endif
        D = hdr(16'd5, 1'b0); D_VALID = 1'b1;
        @(negedge CLK); D = 64'h0000_0000_0000_0001;
        @(negedge CLK); D = 64'h0000_0000_0000_0002;
        @(negedge CLK); D_VALID = 1'b0;
        wait_drain("t5_pre_drain");
        D = 64'h0000_0000_0000_0003; D_VALID = 1'b1; SYS_RST_N = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("rst2a");
        D_VALID = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("rst2b");
        SYS_RST_N = 1'b1;
        @(negedge CLK);
        h = hdr(16'd1, 1'b0);
`ifdef PE_DEMUX_HDR_FWD_EN
        sb.push_back(mk(1'b0, h, -1));
`endif
        sb.push_back(mk(1'b0, 64'h7777_0000_0000_0007, -1));
        D = h; D_VALID = 1'b1;
        @(negedge CLK); D = 64'h7777_0000_0000_0007;
        @(negedge CLK); D_VALID = 1'b0;
        wait_drain("t5_drain");
        chk("t5_q0_y", Q0, 64'h7777_0000_0000_0007);
        chk("t5_q1_zero", Q1, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
